// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter.
package counter_pkg;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    localparam int unsigned FLAG_W = 3;

    typedef struct packed {
        logic wrap;
        logic ovf;
        logic unf;
    } cnt_flags_t;

endpackage

// File: rtl/cnt_reg.sv
// Generic-width state register with asynchronous active-low reset to zero.
module cnt_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= '0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/param_counter.sv
// Modulo-N up/down counter with load, clear, wrap/saturate ends and sticky range-end flags.
module param_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 3,
    parameter longint unsigned  MODULUS  = 8,
    parameter int unsigned      SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 64'd1);
    localparam bit               HOLD_ENDS = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;
    cnt_flags_t       flags_d;
    cnt_flags_t       flags_q;
    logic             at_max;
    logic             at_min;
    logic             load_in_range;

    assign at_max        = (count_q == MAX_VAL);
    assign at_min        = (count_q == '0);
    assign load_in_range = (64'(load_val) < MODULUS);

    // Next state: clear > load > en; wrap is a pulse so it defaults low every cycle.
    always_comb begin
        count_d      = count_q;
        flags_d      = flags_q;
        flags_d.wrap = 1'b0;
        if (clear) begin
            count_d     = '0;
            flags_d.ovf = 1'b0;
            flags_d.unf = 1'b0;
        end else if (load) begin
            count_d = load_in_range ? load_val : MAX_VAL;
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    count_d      = HOLD_ENDS ? count_q : '0;
                    flags_d.ovf  = 1'b1;
                    flags_d.wrap = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_min) begin
                    count_d      = HOLD_ENDS ? count_q : MAX_VAL;
                    flags_d.unf  = 1'b1;
                    flags_d.wrap = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    cnt_reg #(.W(WIDTH)) u_count_reg (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (count_d),
        .q_o   (count_q)
    );

    cnt_reg #(.W(FLAG_W)) u_flag_reg (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (flags_d),
        .q_o   (flags_q)
    );

    assign tc    = en & ((up_dn & at_max) | (~up_dn & at_min));
    assign count = count_q;
    assign wrap  = flags_q.wrap;
    assign ovf   = flags_q.ovf;
    assign unf   = flags_q.unf;

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: three configurations share one stimulus stream against a rule-level model.
module tb_param_counter;

    localparam int NI = 3;
    localparam int MODS [NI] = '{8, 6, 2};
    localparam int SATS [NI] = '{0, 1, 0};

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       clear    = 1'b0;
    logic       load     = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic       en       = 1'b0;
    logic       up_dn    = 1'b0;

    logic [2:0] d_cnt  [NI];
    logic       d_tc   [NI];
    logic       d_wrap [NI];
    logic       d_ovf  [NI];
    logic       d_unf  [NI];

    int m_cnt  [NI] = '{0, 0, 0};
    bit m_wrap [NI] = '{0, 0, 0};
    bit m_ovf  [NI] = '{0, 0, 0};
    bit m_unf  [NI] = '{0, 0, 0};

    int n_cmp    = 0;
    int n_bad    = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    param_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_dut8 (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(d_cnt[0]), .tc(d_tc[0]),
        .wrap(d_wrap[0]), .ovf(d_ovf[0]), .unf(d_unf[0])
    );

    param_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) u_dut6 (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(d_cnt[1]), .tc(d_tc[1]),
        .wrap(d_wrap[1]), .ovf(d_ovf[1]), .unf(d_unf[1])
    );

    param_counter #(.WIDTH(3), .MODULUS(2), .SATURATE(0)) u_dut2 (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(d_cnt[2]), .tc(d_tc[2]),
        .wrap(d_wrap[2]), .ovf(d_ovf[2]), .unf(d_unf[2])
    );

    function automatic void check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
        end
    endfunction

    // Reference behaviour: one range of MODS[i] values, stepping per edge.
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst) begin
                m_cnt[i]  = 0;
                m_wrap[i] = 1'b0;
                m_ovf[i]  = 1'b0;
                m_unf[i]  = 1'b0;
            end else begin
                m_wrap[i] = 1'b0;
                if (clear) begin
                    m_cnt[i] = 0;
                    m_ovf[i] = 1'b0;
                    m_unf[i] = 1'b0;
                end else if (load) begin
                    m_cnt[i] = (int'(load_val) < MODS[i]) ? int'(load_val) : MODS[i] - 1;
                end else if (en && up_dn) begin
                    if (m_cnt[i] + 1 >= MODS[i]) begin
                        m_cnt[i]  = (SATS[i] != 0) ? MODS[i] - 1 : 0;
                        m_ovf[i]  = 1'b1;
                        m_wrap[i] = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end else if (en) begin
                    if (m_cnt[i] - 1 < 0) begin
                        m_cnt[i]  = (SATS[i] != 0) ? 0 : MODS[i] - 1;
                        m_unf[i]  = 1'b1;
                        m_wrap[i] = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
        end
    end

    // Every falling edge: DUT outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < NI; i++) begin
                bit exp_tc;
                exp_tc = en && ((up_dn && m_cnt[i] == MODS[i] - 1) || (!up_dn && m_cnt[i] == 0));
                check("count", i, 32'(d_cnt[i]),  32'(m_cnt[i]));
                check("tc",    i, 32'(d_tc[i]),   32'(exp_tc));
                check("wrap",  i, 32'(d_wrap[i]), 32'(m_wrap[i]));
                check("ovf",   i, 32'(d_ovf[i]),  32'(m_ovf[i]));
                check("unf",   i, 32'(d_unf[i]),  32'(m_unf[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_a [9]    = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        int exp_b [4]    = '{1, 0, 0, 0};
        int exp_bw [4]   = '{0, 0, 1, 1};

        #1 rst = 1'b0;
        #2;
        check("rst_count", 0, 32'(d_cnt[0]),  32'd0);
        check("rst_wrap",  0, 32'(d_wrap[0]), 32'd0);
        check("rst_ovf",   0, 32'(d_ovf[0]),  32'd0);
        check("rst_unf",   0, 32'(d_unf[0]),  32'd0);
        #9 rst = 1'b1;
        checking = 1'b1;
        tick();

        // Free-running up count across the 7->0 wrap; MODULUS=2 toggles.
        en    = 1'b1;
        up_dn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("up8_count", k, 32'(d_cnt[0]), 32'(exp_a[k-1]));
            check("m2_count",  k, 32'(d_cnt[2]), 32'(k % 2));
            check("m2_wrap",   k, 32'(d_wrap[2]), 32'((k % 2) == 0));
            if (k == 8) check("up8_wrap", k, 32'(d_wrap[0]), 32'd1);
            if (k == 9) begin
                check("up8_wrap", k, 32'(d_wrap[0]), 32'd0);
                check("up8_ovf",  k, 32'(d_ovf[0]),  32'd1);
                check("sat6_hold", k, 32'(d_cnt[1]), 32'd5);
                check("sat6_wrap", k, 32'(d_wrap[1]), 32'd1);
            end
        end

        // Saturating down count from 2 into the bottom end.
        en       = 1'b0;
        load     = 1'b1;
        load_val = 3'd2;
        tick();
        check("sat6_load", 0, 32'(d_cnt[1]), 32'd2);
        load  = 1'b0;
        en    = 1'b1;
        up_dn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("dn6_count", k, 32'(d_cnt[1]),  32'(exp_b[k]));
            check("dn6_wrap",  k, 32'(d_wrap[1]), 32'(exp_bw[k]));
            if (k >= 1) check("dn6_tc", k, 32'(d_tc[1]), 32'd1);
        end
        check("dn6_unf", 0, 32'(d_unf[1]), 32'd1);

        // Out-of-range load clamps; load beats en.
        load     = 1'b1;
        up_dn    = 1'b1;
        load_val = 3'd7;
        tick();
        check("clamp6_count", 0, 32'(d_cnt[1]),  32'd5);
        check("clamp6_wrap",  0, 32'(d_wrap[1]), 32'd0);
        check("load8_count",  0, 32'(d_cnt[0]),  32'd7);

        // Clear beats load and drops sticky flags.
        en       = 1'b0;
        load_val = 3'd4;
        tick();
        check("ld4_count", 0, 32'(d_cnt[0]), 32'd4);
        check("ld4_ovf",   0, 32'(d_ovf[0]), 32'd1);
        clear    = 1'b1;
        load_val = 3'd6;
        tick();
        check("clr_count", 0, 32'(d_cnt[0]), 32'd0);
        check("clr_ovf",   0, 32'(d_ovf[0]), 32'd0);
        check("clr_unf",   0, 32'(d_unf[0]), 32'd0);
        clear = 1'b0;

        // Async reset mid-cycle at count=5 with ovf set.
        load_val = 3'd7;
        tick();
        load = 1'b0;
        en   = 1'b1;
        tick();
        load     = 1'b1;
        en       = 1'b0;
        load_val = 3'd5;
        tick();
        load = 1'b0;
        check("pre_rst_count", 0, 32'(d_cnt[0]), 32'd5);
        check("pre_rst_ovf",   0, 32'(d_ovf[0]), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_count", 0, 32'(d_cnt[0]),  32'd0);
        check("async_ovf",   0, 32'(d_ovf[0]),  32'd0);
        check("async_wrap",  0, 32'(d_wrap[0]), 32'd0);
        check("async_unf",   0, 32'(d_unf[0]),  32'd0);
        en    = 1'b1;
        up_dn = 1'b1;
        tick();
        check("in_rst_count", 0, 32'(d_cnt[0]), 32'd0);
        #3 rst = 1'b1;
        tick();
        check("restart_count", 0, 32'(d_cnt[0]), 32'd1);

        // Randomised traffic, with occasional mid-cycle reset pulses.
        for (int n = 0; n < 3000; n++) begin
            clear    = ($urandom % 16) == 0;
            load     = ($urandom % 8) == 0;
            load_val = 3'($urandom);
            en       = ($urandom % 4) != 0;
            up_dn    = ($urandom % 3) != 0 ? (n / 200) % 2 == 0 : 1'($urandom);
            if (($urandom % 128) == 0) begin
                #2 rst = 1'b0;
                #1 rst = 1'b1;
            end
            tick();
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
